// File: rtl/serial_addsub_5bits.sv
// serial_addsub_5bits
//   Bit-serial two's complement adder/subtractor. One full adder processes
//   one bit per clock, LSB first, over WIDTH cycles.
//
//   Optional feature macro: OVERFLOW_DETECT_EN
//     defined   -> signed overflow is produced from a captured MSB carry-in
//     undefined -> overflow is tied to 0 and no extra flop is built
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   start    in   request, accepted only in IDLE
//   sub      in   0: a+b, 1: a-b
//   a, b     in   WIDTH-bit two's complement operands
//   busy     out  high while bits are being shifted
//   done     out  one-cycle pulse, result valid
//   result   out  WIDTH-bit sum/difference, held until the next accepted start
//   cout     out  carry out of the MSB (for subtraction: 1 = no borrow)
//   overflow out  signed overflow flag

module serial_addsub_5bits #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

`ifdef OVERFLOW_DETECT_EN
  logic             msb_cin_q;  // carry into the MSB position
`endif

  // Single full adder; b is inverted on the fly for subtraction, the +1 comes
  // from the carry flop being preset to sub at acceptance.
  logic b_bit;
  logic sum_bit;
  logic carry_next;

  always_comb begin
    b_bit      = b_q[0] ^ sub_q;
    sum_bit    = a_q[0] ^ b_bit ^ carry_q;
    carry_next = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      msb_cin_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= sub;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end

        StShift: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_next;
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
          result  <= {sum_bit, result[WIDTH-1:1]};
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            cout      <= carry_next;
`ifdef OVERFLOW_DETECT_EN
            msb_cin_q <= carry_q;
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= StDone;
          end
        end

        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef OVERFLOW_DETECT_EN
  assign overflow = msb_cin_q ^ cout;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_5bits.sv
module tb_serial_addsub_5bits;

  localparam int W = 5;

`ifdef OVERFLOW_DETECT_EN
  localparam bit OvfOn = 1'b1;
`else
  localparam bit OvfOn = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  serial_addsub_5bits #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    int   ux, uy, full, sx, sy, sr;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
    sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
    full = s ? (ux - uy) : (ux + uy);
    sr   = s ? (sx - sy) : (sx + sy);
    e.r = W'(full & ((1 << W) - 1));
    e.c = s ? (ux >= uy) : ((ux + uy) >= (1 << W));
    e.o = OvfOn && ((sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1))));
    return e;
  endfunction

  // Compare process: checks every done pulse against the model queue, and
  // checks that outputs hold while idle after a completed operation.
  exp_t hold;
  bit   hold_valid = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      hold_valid = 1'b0;
    end else if (done) begin
      done_cnt++;
      chk("busy_low_at_done", int'(busy), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        hold = exp_q.pop_front();
        chk("result", int'(result), int'(hold.r));
        chk("cout", int'(cout), int'(hold.c));
        chk("overflow", int'(overflow), int'(hold.o));
        hold_valid = 1'b1;
      end
    end else if (!busy && hold_valid) begin
      chk("hold_result", int'(result), int'(hold.r));
      chk("hold_cout", int'(cout), int'(hold.c));
      chk("hold_overflow", int'(overflow), int'(hold.o));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1 with the DUT idle. mode 0: quiet inputs,
  // mode 1: operands/sub scrambled during SHIFT, mode 2: extra start pulse
  // on the 2nd SHIFT cycle with different operands.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input int mode, output logic [W-1:0] r, output logic c,
                       output logic o);
    int edges;
    int busy_cnt;
    int dn0;
    dn0   = done_cnt;
    a     = ta;
    b     = tb_v;
    sub   = ts;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(ta, tb_v, ts));
    #1;
    start    = 1'b0;
    edges    = 1;
    busy_cnt = busy ? 1 : 0;
    while (edges < 20 && !done) begin
      if (mode == 1) begin
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
      end
      if (mode == 2) begin
        start = (edges == 2);
        if (edges == 2) begin
          a   = ~ta;
          b   = ta ^ tb_v;
          sub = ~ts;
        end
      end
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk("latency_edges", edges, W + 1);
    chk("busy_cycles", busy_cnt, W);
    r = result;
    c = cout;
    o = overflow;
    idle((mode == 2) ? 8 : 1);
    chk("single_done", done_cnt - dn0, 1);
  endtask

  logic [W-1:0] r;
  logic         c;
  logic         o;
  int           dn_before;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Hand-computed pins
    do_op(5'b00111, 5'b01010, 1'b1, 0, r, c, o);
    chk("lit_7m10_r", int'(r), 5'b11101);
    chk("lit_7m10_c", int'(c), 0);
    chk("lit_7m10_o", int'(o), 0);

    do_op(5'b01111, 5'b10000, 1'b1, 0, r, c, o);
    chk("lit_15mn16_r", int'(r), 5'b11111);
    chk("lit_15mn16_c", int'(c), 0);
    chk("lit_15mn16_o", int'(o), OvfOn ? 1 : 0);

    do_op(5'b01010, 5'b00111, 1'b0, 0, r, c, o);
    chk("lit_10p7_r", int'(r), 5'b10001);
    chk("lit_10p7_c", int'(c), 0);
    chk("lit_10p7_o", int'(o), OvfOn ? 1 : 0);

    do_op(5'b00111, 5'b00111, 1'b1, 0, r, c, o);
    chk("lit_7m7_r", int'(r), 5'b00000);
    chk("lit_7m7_c", int'(c), 1);
    chk("lit_7m7_o", int'(o), 0);

    // Second start during SHIFT is ignored
    do_op(5'b00011, 5'b00101, 1'b0, 2, r, c, o);
    chk("ignore_start_r", int'(r), 5'b01000);

    // Operand changes during SHIFT do not matter; result holds afterwards
    do_op(5'b10110, 5'b00011, 1'b1, 1, r, c, o);
    chk("scramble_r", int'(r), 5'b10011);
    chk("scramble_c", int'(c), 1);
    idle(4);

    // Reset on the 3rd SHIFT cycle
    dn_before = done_cnt;
    a     = 5'b01101;
    b     = 5'b00110;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    idle(2);
    reset = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_cout", int'(cout), 0);
    chk("midrst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(10);
    chk("midrst_no_done", done_cnt - dn_before, 0);
    do_op(5'b01101, 5'b00110, 1'b0, 0, r, c, o);
    chk("after_rst_r", int'(r), 5'b10011);

    // Randomized operations checked by the compare process
    for (int i = 0; i < 60; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), r, c, o);
      for (int j = int'($urandom_range(0, 3)); j > 0; j--) begin
        a = W'($urandom);
        b = W'($urandom);
        idle(1);
      end
    end

    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub_5bits.md
SERIAL_ADDSUB_5BITS -- requirements
Module: serial_addsub_5bits

Interface
REQ-001 Parameter: WIDTH, default 5, operand/result width in bits; shall be >= 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled on a clk edge only in IDLE.
REQ-005 sub  input  1  mode: 0 = a+b, 1 = a-b via two's complement of b (invert b, carry-in 1).
REQ-006 a  input  WIDTH  first operand, two's complement.
REQ-007 b  input  WIDTH  second operand, two's complement.
REQ-008 busy  output  1  high while in SHIFT.
REQ-009 done  output  1  one-cycle pulse marking result valid.
REQ-010 result  output  WIDTH  sum/difference, valid from done until the next accepted start.
REQ-011 cout  output  1  carry out of the MSB bit position.
REQ-012 overflow  output  1  signed overflow flag; see REQ-027/028.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 at an edge shall load a and b into internal shift registers, latch sub, set the carry flop to sub, clear the bit counter, and move to SHIFT.
REQ-015 IDLE: start=0 shall hold all state and outputs.
REQ-016 SHIFT: each cycle shall process one bit, LSB first, with a single full adder: a_bit + (b_bit XOR sub_latched) + carry.
REQ-017 SHIFT: each sum bit shall shift into result from the MSB end; the carry flop shall take the full-adder carry; the operand registers shall shift right by one.
REQ-018 SHIFT shall last exactly WIDTH cycles, then move to DONE.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle, then unconditional move to IDLE.
REQ-020 Latency: done is high in the cycle after WIDTH+1 clock edges counting from the edge that accepted start.
REQ-021 result, cout and overflow shall change only during SHIFT; they are stable from done until the next accepted start.
REQ-022 start in SHIFT or DONE shall be ignored; it is neither queued nor restarted.
REQ-023 Changes to a, b or sub after acceptance shall not affect the operation in progress.
REQ-024 Arithmetic is modulo 2^WIDTH; cout = carry out of bit WIDTH-1.
REQ-025 Subtraction: cout=1 means no borrow (a >= b, unsigned).

Reset
REQ-026 reset=1 shall immediately (asynchronously) force IDLE with busy=0, done=0, result=0, cout=0, overflow=0, carry, counter and operand registers=0; an operation in progress is abandoned with no done pulse.

Configuration
REQ-027 With OVERFLOW_DETECT_EN defined: a one-bit flop shall capture the carry into the MSB during the last SHIFT cycle; overflow = that carry XOR cout, valid with done.
REQ-028 Without OVERFLOW_DETECT_EN: overflow shall be a constant 0 and no extra flop shall be instantiated; all other behaviour is unchanged.

Verification
REQ-029 sub=1, a=00111, b=01010, start pulse -> done after 6 edges; result=11101 (-3), cout=0, overflow=0; busy high for exactly 5 cycles.
REQ-030 sub=1, a=01111, b=10000 -> result=11111, cout=0, overflow=1 with the macro, 0 without it.
REQ-031 sub=0, a=01010, b=00111 -> result=10001, cout=0, overflow=1 with the macro; sub=1, a=b=00111 -> result=00000, cout=1, overflow=0.
REQ-032 Start an operation, then pulse start again on the 2nd SHIFT cycle with different operands -> the first result completes unchanged and only one done pulse occurs.
REQ-033 Assert reset on the 3rd SHIFT cycle -> all outputs 0 immediately, FSM in IDLE, no done pulse; a following start computes correctly.
REQ-034 Change a and b during SHIFT -> result matches the values captured at start; result holds after done while start stays 0.
